valve_pwm_ctrl: RTL and testbench
=================================

// Module: valve_pwm_ctrl
// PURPOSE
// - Consumes the 1 kHz square wave from the clock divider and drives NUM_CH valve outputs.
//   Each output is a millisecond-resolution PWM signal with a common period of PERIOD_MS ticks.
// - Sits between the processor command path and the valve driver pins.
// - Duty commands are written into shadow registers and take effect only at a period boundary.
//   This prevents glitches on the valve outputs.
// PARAMETERS
// - NUM_CH    4    number of valve channels
// - DUTY_W    8    width of a duty value, in ticks
// - PERIOD_MS 20   PWM period in 1 ms ticks; legal range 2..2**DUTY_W-1
// - CH_W      2    channel index width; must equal clog2(NUM_CH), minimum 1
// PORTS
// - clk_100m   in   1              system clock, 100 MHz
// - rst        in   1              asynchronous reset, active-high
// - clk_1k     in   1              1 kHz square wave, generated by a flop on clk_100m (same domain, no synchronizer)
// - en         in   1              global enable; 0 forces all valves closed
// - cmd_valid  in   1              duty command valid
// - cmd_ready  out  1              block can accept a command this cycle
// - cmd_ch     in   CH_W           target channel index
// - cmd_duty   in   DUTY_W         on-time in ticks per period
// - cmd_err    out  1              1-cycle pulse: accepted command had cmd_ch >= NUM_CH
// - valve_out  out  NUM_CH         valve drive, 1 = open
// - period_strt out 1              1-cycle pulse when a new PWM period begins
// BEHAVIOUR
// - Reset (async, rst=1): clk_1k_d, phase, all shadow and active duties, valve_out, cmd_err and period_strt are cleared to 0.
// - tick: tick = clk_1k & ~clk_1k_d. It is 1 for exactly one cycle per rising edge (one per 100000 cycles).
//   The first tick after reset is counted only if clk_1k actually rises; a level of 1 at reset release is not a tick.
// - phase, DUTY_W bits, counts 0..PERIOD_MS-1:
//   - increments on tick;
//   - on a tick with phase==PERIOD_MS-1 it wraps to 0. This cycle is called a boundary.
// - On a boundary: active_duty[i] <= shadow_duty[i] for all i, and period_strt=1 in the next cycle.
// - Handshake:
//   - transfer = cmd_valid & cmd_ready;
//   - cmd_ready = ~boundary (combinational), so a write can never collide with a shadow-to-active copy;
//   - on a transfer with cmd_ch < NUM_CH: shadow_duty[cmd_ch] <= cmd_duty;
//   - on a transfer with cmd_ch >= NUM_CH: the write is dropped and cmd_err=1 in the next cycle;
//   - several writes to the same channel within one period: the last one wins.
// - Output: valve_out[i] <= en & (phase < active_duty[i]). It is registered, so it lags phase by 1 clk_100m cycle.
//   - duty 0: always closed.
//   - duty >= PERIOD_MS: always open.
// - Disable (en=0):
//   - phase is held at 0 and active_duty <= shadow_duty every cycle;
//   - period_strt is not pulsed;
//   - valve_out is 0 from the next cycle;
//   - commands are still accepted.
// - Re-enable: the first period starts at phase 0 with the latest shadow duties.
//   - Valves with non-zero duty open 1 cycle after en rises.
//   - The first boundary occurs PERIOD_MS ticks after re-enable.
// - Reset mid-period: outputs drop to 0 immediately (asynchronous). Shadow values are lost; software must rewrite duties.
// - FSM, 2 states:
//   - IDLE (en=0): phase frozen at 0, active duties track shadow duties.
//   - RUN (en=1): phase counts and active duties update only on boundaries.
//   - IDLE->RUN on en=1; RUN->IDLE on en=0. The state is reset to IDLE.
// STRUCTURE
// - Package valve_pkg: NUM_CH, DUTY_W, CH_W, PERIOD_MS defaults, and the state encoding localparams (S_IDLE, S_RUN).
// - Sub-module tick_edge_detect (clk_100m, rst, in, pulse): rising-edge pulse generator, reusable for other 1 kHz consumers.
// - Top level: FSM, phase counter, shadow/active register arrays, per-channel compare generate loop.
// TESTING
// The bench drives clk_1k directly with a short period (e.g. toggle every 5 cycles) and uses PERIOD_MS=20.
// - Reset then en=1:
//   - write ch0=5, ch1=0, ch2=20, ch3=10;
//   - after the first boundary, valve_out is open for 5/0/20/10 ticks per period;
//   - period_strt pulses once every 20 ticks.
// - Write ch0=15 mid-period while ch0 is running at 5: the current period still shows 5 ticks, and the next period shows 15.
// - Hold cmd_valid across a boundary tick:
//   - cmd_ready=0 in exactly that cycle;
//   - the write lands 1 cycle later and applies one period later.
// - With NUM_CH=3 (CH_W=2), write cmd_ch=3: cmd_err pulses for 1 cycle and no shadow register changes.
// - Drop en mid-period: valve_out=0 next cycle and phase=0.
//   Raise en again: ch0 (duty 5) opens 1 cycle later and closes after 5 ticks.
// - Assert rst at phase 12 with valves open: all outputs go to 0 without waiting for a clock edge.
//   Release rst with clk_1k high: no tick occurs until the next rising edge.

Source files
------------

// File: rtl/valve_pkg.sv
// rtl/valve_pkg.sv - shared defaults and state encoding for the valve PWM controller
package valve_pkg;

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_DUTY_W    = 8;
    localparam int DEF_PERIOD_MS = 20;
    localparam int DEF_CH_W      = 2;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/tick_edge_detect.sv
// rtl/tick_edge_detect.sv - one-cycle pulse on each rising edge of a same-domain slow square wave
module tick_edge_detect (
    input  logic clk_100m,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic in_q;
    logic in_d;
    logic armed_q;
    logic armed_d;

    always_comb begin
        in_d    = in;
        armed_d = 1'b1;
    end

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            in_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            in_q    <= in_d;
            armed_q <= armed_d;
        end
    end

    // armed_q masks the first cycle after reset, so a level already high at release is not an edge
    assign pulse = in & ~in_q & armed_q;

endmodule

// File: rtl/valve_pwm_ctrl.sv
// rtl/valve_pwm_ctrl.sv - multi-channel millisecond PWM valve driver with boundary-latched duty commands
module valve_pwm_ctrl
    import valve_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int DUTY_W    = DEF_DUTY_W,
    parameter int PERIOD_MS = DEF_PERIOD_MS,
    parameter int CH_W      = DEF_CH_W
) (
    input  logic              clk_100m,
    input  logic              rst,
    input  logic              clk_1k,
    input  logic              en,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [DUTY_W-1:0] cmd_duty,
    output logic              cmd_err,
    output logic [NUM_CH-1:0] valve_out,
    output logic              period_strt
);

    localparam logic [DUTY_W-1:0] LAST_PHASE = DUTY_W'(PERIOD_MS - 1);
    localparam logic [CH_W:0]     NUM_CH_L   = (CH_W + 1)'(NUM_CH);

    state_e            state_q, state_d;
    logic [DUTY_W-1:0] phase_q, phase_d;
    logic [DUTY_W-1:0] shadow_q [NUM_CH];
    logic [DUTY_W-1:0] shadow_d [NUM_CH];
    logic [DUTY_W-1:0] active_q [NUM_CH];
    logic [DUTY_W-1:0] active_d [NUM_CH];
    logic [NUM_CH-1:0] valve_q, valve_d;
    logic              err_q, err_d;
    logic              pstrt_q, pstrt_d;

    logic tick;
    logic run;
    logic boundary;
    logic transfer;
    logic ch_ok;

    tick_edge_detect u_tick (
        .clk_100m (clk_100m),
        .rst      (rst),
        .in       (clk_1k),
        .pulse    (tick)
    );

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = en ? S_RUN : S_IDLE;
            S_RUN:   state_d = en ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Acting on the next state lets a falling en freeze the phase in the same cycle.
    assign run       = (state_d == S_RUN);
    assign boundary  = run & tick & (phase_q == LAST_PHASE);
    assign cmd_ready = ~boundary;
    assign transfer  = cmd_valid & cmd_ready;
    assign ch_ok     = ({1'b0, cmd_ch} < NUM_CH_L);

    always_comb begin
        phase_d  = phase_q;
        shadow_d = shadow_q;
        active_d = active_q;
        err_d    = transfer & ~ch_ok;
        pstrt_d  = boundary;

        if (!run) begin
            phase_d = '0;
        end else if (tick) begin
            phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
        end

        for (int i = 0; i < NUM_CH; i++) begin
            if (!run || boundary) begin
                active_d[i] = shadow_q[i];
            end
            if (transfer && ch_ok && (cmd_ch == CH_W'(i))) begin
                shadow_d[i] = cmd_duty;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cmp
        assign valve_d[g] = run & (phase_q < active_q[g]);
    end

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            valve_q <= '0;
            err_q   <= 1'b0;
            pstrt_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            valve_q  <= valve_d;
            err_q    <= err_d;
            pstrt_q  <= pstrt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign valve_out   = valve_q;
    assign cmd_err     = err_q;
    assign period_strt = pstrt_q;

endmodule

// File: tb/tb_valve_pwm_ctrl.sv
// tb/tb_valve_pwm_ctrl.sv - randomized bench for valve_pwm_ctrl against a period-level reference model
module tb_valve_pwm_ctrl;

    localparam int PERIOD = 20;

    logic       clk;
    logic       rst;
    logic       clk_1k;
    logic       en;
    logic       cmd_valid;
    logic [1:0] cmd_ch;
    logic [7:0] cmd_duty;

    logic       ready4, ready3;
    logic       err4, err3;
    logic       ps4, ps3;
    logic [3:0] valve4;
    logic [2:0] valve3;

    valve_pwm_ctrl #(.NUM_CH(4), .DUTY_W(8), .PERIOD_MS(PERIOD), .CH_W(2)) dut4 (
        .clk_100m (clk), .rst (rst), .clk_1k (clk_1k), .en (en),
        .cmd_valid (cmd_valid), .cmd_ready (ready4), .cmd_ch (cmd_ch), .cmd_duty (cmd_duty),
        .cmd_err (err4), .valve_out (valve4), .period_strt (ps4)
    );

    valve_pwm_ctrl #(.NUM_CH(3), .DUTY_W(8), .PERIOD_MS(PERIOD), .CH_W(2)) dut3 (
        .clk_100m (clk), .rst (rst), .clk_1k (clk_1k), .en (en),
        .cmd_valid (cmd_valid), .cmd_ready (ready3), .cmd_ch (cmd_ch), .cmd_duty (cmd_duty),
        .cmd_err (err3), .valve_out (valve3), .period_strt (ps3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference: the position in the period, and per instance the pending and live duty tables.
    int   m_phase;
    logic m_prev;
    logic m_armed;
    int   m_shadow [2][4];
    int   m_active [2][4];
    int   div_cnt;
    logic last_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_prev  = 1'b0;
        m_armed = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                m_shadow[k][i] = 0;
                m_active[k][i] = 0;
            end
        end
    endtask

    // Called just after a falling clock edge; predicts what the next rising edge produces.
    task automatic cycle_eval(input logic v, input logic [1:0] ch, input logic [7:0] duty);
        logic       tick, bnd, xfer;
        logic [3:0] ev [2];
        logic       ee [2];
        int         nch;
        cmd_valid = v;
        cmd_ch    = ch;
        cmd_duty  = duty;
        #1;
        tick = clk_1k && !m_prev && m_armed;
        bnd  = en && tick && (m_phase == PERIOD - 1);
        xfer = v && !bnd;
        check("ready4", ready4, !bnd);
        check("ready3", ready3, !bnd);
        last_ready = ready4;
        for (int k = 0; k < 2; k++) begin
            nch   = (k == 0) ? 4 : 3;
            ev[k] = '0;
            for (int i = 0; i < nch; i++) ev[k][i] = en && (m_phase < m_active[k][i]);
            ee[k] = xfer && (int'(ch) >= nch);
            for (int i = 0; i < nch; i++) if (!en || bnd) m_active[k][i] = m_shadow[k][i];
            if (xfer && int'(ch) < nch) m_shadow[k][ch] = int'(duty);
        end
        if (!en) m_phase = 0;
        else if (tick) m_phase = (m_phase + 1) % PERIOD;
        m_prev  = clk_1k;
        m_armed = 1'b1;
        @(posedge clk);
        #1;
        check("valve4", valve4, ev[0]);
        check("valve3", valve3, ev[1][2:0]);
        check("err4", err4, ee[0]);
        check("err3", err3, ee[1]);
        check("pstrt4", ps4, bnd);
        check("pstrt3", ps3, bnd);
    endtask

    task automatic step(input logic v, input logic [1:0] ch, input logic [7:0] duty);
        @(negedge clk);
        div_cnt++;
        if (div_cnt == 5) begin
            div_cnt = 0;
            clk_1k  = ~clk_1k;
        end
        cycle_eval(v, ch, duty);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 8'd0);
    endtask

    task automatic run_to_phase(input int ph);
        int n = 0;
        while (m_phase != ph && n < 500) begin
            step(1'b0, 2'd0, 8'd0);
            n++;
        end
        check("phase_reached", (n < 500), 1);
    endtask

    task automatic release_reset(input logic k1);
        @(negedge clk);
        clk_1k  = k1;
        rst     = 1'b0;
        div_cnt = 0;
        model_reset();
        cycle_eval(1'b0, 2'd0, 8'd0);
    endtask

    initial begin
        int ready_low;
        rst       = 1'b1;
        clk_1k    = 1'b0;
        en        = 1'b0;
        cmd_valid = 1'b0;
        cmd_ch    = '0;
        cmd_duty  = '0;
        div_cnt   = 0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_valve4", valve4, 0);
        check("rst_valve3", valve3, 0);
        check("rst_err", err4, 0);
        check("rst_pstrt", ps4, 0);
        release_reset(1'b0);

        en = 1'b1;
        step(1'b1, 2'd0, 8'd5);
        step(1'b1, 2'd1, 8'd0);
        step(1'b1, 2'd2, 8'd20);
        step(1'b1, 2'd3, 8'd10);
        idle(3 * PERIOD * 10);

        run_to_phase(10);
        step(1'b1, 2'd0, 8'd15);
        idle(2 * PERIOD * 10);

        // Exactly one period of held valid spans exactly one boundary cycle.
        ready_low = 0;
        for (int i = 0; i < PERIOD * 10; i++) begin
            step(1'b1, 2'd1, 8'd7);
            if (!last_ready) ready_low++;
        end
        check("ready_low_cycles", ready_low, 1);
        idle(2 * PERIOD * 10);

        step(1'b1, 2'd3, 8'd9);
        step(1'b1, 2'd0, 8'd5);
        idle(PERIOD * 10);
        run_to_phase(7);
        en = 1'b0;
        idle(30);
        en = 1'b1;
        idle(300);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) en = ~en;
            step(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 25)));
        end

        en = 1'b1;
        for (int c = 0; c < 4; c++) step(1'b1, 2'(c), 8'd25);
        idle(2 * PERIOD * 10);
        run_to_phase(12);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valve4", valve4, 0);
        check("async_rst_valve3", valve3, 0);
        repeat (3) @(negedge clk);
        release_reset(1'b1);
        step(1'b1, 2'd0, 8'd5);
        step(1'b1, 2'd2, 8'd20);
        idle(2 * PERIOD * 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
